qsys_system_ain_bank: RTL and testbench

Parametrised multi-channel analog-input capture slave for the Qsys system: latches NUM_CH ADC results of DATA_W bits on a conversion strobe, keeps per-channel live, block-average, min and max values, flags over-threshold samples, and exposes everything on an Avalon-MM slave with a registered read path and a level interrupt. It supersedes the per-channel raw-sample PIO slaves and sits between the ADC interface logic and the system interconnect.

---
 rtl/qsys_system_ain_pkg.sv | 37 +++
 rtl/qsys_system_ain_chan.sv | 89 ++++++++
 rtl/qsys_system_ain_bank.sv | 176 +++++++++++++++++
 tb/tb_qsys_system_ain_bank.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qsys_system_ain_pkg.sv
// Shared definitions for the analog-input capture bank: register map,
// CTRL/STATUS bit positions and the address-width sanity check.
package qsys_system_ain_pkg;

   // Word offsets of the global registers
   localparam int REG_CTRL   = 0;
   localparam int REG_STATUS = 1;
   localparam int REG_THRESH = 2;
   localparam int REG_RSVD   = 3;

   // Per-channel register block: channel k starts at CH_BASE + CH_STRIDE*k
   localparam int CH_BASE   = 4;
   localparam int CH_STRIDE = 4;

   // Register within a channel block, selected by the two low address bits
   typedef enum logic [1:0] {
      CH_LIVE = 2'd0,
      CH_AVG  = 2'd1,
      CH_MIN  = 2'd2,
      CH_MAX  = 2'd3
   } ch_reg_e;

   // CTRL bit positions
   localparam int CTRL_EN_BIT     = 0;
   localparam int CTRL_IRQ_EN_BIT = 1;
   localparam int CTRL_MM_CLR_BIT = 2;

   // STATUS bit positions
   localparam int STATUS_AVG_DONE_BIT = 0;
   localparam int STATUS_OVR_LSB      = 8;

   // True when the word address space covers the global block plus every channel block
   function automatic bit addr_w_ok(input int addr_w, input int num_ch);
      return (64'd1 << addr_w) >= 64'(CH_BASE + CH_STRIDE * num_ch);
   endfunction

endpackage

// File: rtl/qsys_system_ain_chan.sv
// One capture channel: live sample, block accumulator and average,
// running min/max, and the over-threshold compare for the current sample.
module qsys_system_ain_chan
   import qsys_system_ain_pkg::*;
#(
   parameter int DATA_W   = 12,
   parameter int AVG_LOG2 = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] sample_i,
   input  logic              take_i,     // sample accepted this cycle (strobe and enabled)
   input  logic              last_i,     // this sample closes the averaging block
   input  logic              clr_i,      // restart min/max tracking
   input  logic [DATA_W-1:0] thresh_i,
   output logic [DATA_W-1:0] live_o,
   output logic [DATA_W-1:0] avg_o,
   output logic [DATA_W-1:0] min_o,
   output logic [DATA_W-1:0] max_o,
   output logic              ovr_set_o
);

   // Wide enough to hold a full block of maximum-value samples
   localparam int ACC_W = DATA_W + AVG_LOG2;

   logic [DATA_W-1:0] live_q, live_d;
   logic [DATA_W-1:0] avg_q,  avg_d;
   logic [DATA_W-1:0] min_q,  min_d;
   logic [DATA_W-1:0] max_q,  max_d;
   logic [ACC_W-1:0]  acc_q,  acc_d;
   logic [ACC_W-1:0]  sum;

   assign sum       = acc_q + ACC_W'(sample_i);
   assign ovr_set_o = take_i && (sample_i > thresh_i);

   // Next-state for live value, block average and min/max tracking
   always_comb begin
      // NOTE: every variable gets a hold default first; an unassigned path would infer a latch.
      live_d = live_q;
      avg_d  = avg_q;
      acc_d  = acc_q;
      min_d  = min_q;
      max_d  = max_q;

      if (take_i) begin
         live_d = sample_i;
         if (last_i) begin
            avg_d = DATA_W'(sum >> AVG_LOG2);
            acc_d = '0;
         end else begin
            acc_d = sum;
         end
      end

      // A clear that coincides with a sample restarts tracking from that sample
      if (clr_i) begin
         min_d = take_i ? sample_i : '1;
         max_d = take_i ? sample_i : '0;
      end else if (take_i) begin
         if (sample_i < min_q) min_d = sample_i;
         if (sample_i > max_q) max_d = sample_i;
      end
   end

   // Channel state registers with synchronous reset
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop sees pre-edge values regardless of statement order.
      if (!reset_n) begin
         // NOTE: these are discrete flops, not a RAM, so each gets an explicit reset; MIN starts all-ones so the first sample wins.
         live_q <= '0;
         avg_q  <= '0;
         acc_q  <= '0;
         min_q  <= '1;
         max_q  <= '0;
      end else begin
         live_q <= live_d;
         avg_q  <= avg_d;
         acc_q  <= acc_d;
         min_q  <= min_d;
         max_q  <= max_d;
      end
   end

   assign live_o = live_q;
   assign avg_o  = avg_q;
   assign min_o  = min_q;
   assign max_o  = max_q;

endmodule

// File: rtl/qsys_system_ain_bank.sv
// Multi-channel analog-input capture slave: per-channel capture units,
// shared averaging counter, CTRL/STATUS/THRESH registers, registered
// Avalon-MM read path and a registered level interrupt.
module qsys_system_ain_bank
   import qsys_system_ain_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int DATA_W   = 12,
   parameter int AVG_LOG2 = 2,
   parameter int ADDR_W   = 6
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [NUM_CH*DATA_W-1:0] in_port,
   input  logic                     in_valid,
   input  logic [ADDR_W-1:0]        address,
   input  logic                     write,
   input  logic [31:0]              writedata,
   output logic [31:0]              readdata,
   output logic                     irq
);

   // Counter spans one averaging block; a block of one sample still needs a 1-bit register
   localparam int              CNT_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

   if (!addr_w_ok(ADDR_W, NUM_CH)) begin : g_addr_w_bad
      $error("ADDR_W is too small to map all channels");
   end

   // Global register state
   logic              en_q,       en_d;
   logic              irq_en_q,   irq_en_d;
   logic              avg_done_q, avg_done_d;
   logic [NUM_CH-1:0] ovr_q,      ovr_d;
   logic [DATA_W-1:0] thresh_q,   thresh_d;
   logic [CNT_W-1:0]  cnt_q,      cnt_d;
   logic [31:0]       rd_q,       rd_d;
   logic              irq_q,      irq_d;

   // Decoded strobes
   logic              wr_ctrl, wr_status, wr_thresh;
   logic              mm_clr, take, cnt_last;
   logic              w1c_done;
   logic [NUM_CH-1:0] w1c_ovr;

   // Channel outputs
   logic [DATA_W-1:0] live_w [NUM_CH];
   logic [DATA_W-1:0] avg_w  [NUM_CH];
   logic [DATA_W-1:0] min_w  [NUM_CH];
   logic [DATA_W-1:0] max_w  [NUM_CH];
   logic [NUM_CH-1:0] ovr_set_w;

   // Read-mux helpers
   logic [ADDR_W-3:0] ch_idx;
   ch_reg_e           ch_reg;

   // Not every writedata bit maps to a register field
   logic unused_wdata;
   assign unused_wdata = ^writedata;

   assign wr_ctrl   = write && (address == ADDR_W'(REG_CTRL));
   assign wr_status = write && (address == ADDR_W'(REG_STATUS));
   assign wr_thresh = write && (address == ADDR_W'(REG_THRESH));
   assign mm_clr    = wr_ctrl && writedata[CTRL_MM_CLR_BIT];
   assign take      = in_valid && en_q;
   assign cnt_last  = (cnt_q == CNT_LAST);
   assign w1c_done  = wr_status && writedata[STATUS_AVG_DONE_BIT];
   assign w1c_ovr   = wr_status ? writedata[STATUS_OVR_LSB +: NUM_CH] : '0;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      qsys_system_ain_chan #(
         .DATA_W   (DATA_W),
         .AVG_LOG2 (AVG_LOG2)
      ) u_chan (
         .clk       (clk),
         .reset_n   (reset_n),
         .sample_i  (in_port[k*DATA_W +: DATA_W]),
         .take_i    (take),
         .last_i    (cnt_last),
         .clr_i     (mm_clr),
         .thresh_i  (thresh_q),
         .live_o    (live_w[k]),
         .avg_o     (avg_w[k]),
         .min_o     (min_w[k]),
         .max_o     (max_w[k]),
         .ovr_set_o (ovr_set_w[k])
      );
   end

   // Next-state for control, sticky status, threshold, block counter and irq
   always_comb begin
      en_d     = en_q;
      irq_en_d = irq_en_q;
      if (wr_ctrl) begin
         en_d     = writedata[CTRL_EN_BIT];
         irq_en_d = writedata[CTRL_IRQ_EN_BIT];
      end

      thresh_d = wr_thresh ? writedata[DATA_W-1:0] : thresh_q;

      // Setting a status bit takes priority over clearing it in the same cycle
      avg_done_d = (avg_done_q && !w1c_done) || (take && cnt_last);
      ovr_d      = (ovr_q & ~w1c_ovr) | ovr_set_w;

      cnt_d = cnt_q;
      if (take) begin
         cnt_d = cnt_last ? '0 : cnt_q + CNT_W'(1);
      end

      // irq follows the post-edge register values, so it moves on the same edge as STATUS/CTRL
      irq_d = irq_en_d && (avg_done_d || (|ovr_d));
   end

   // Read data mux; reflects the register state of the addressed cycle
   always_comb begin
      rd_d   = '0;
      ch_idx = address[ADDR_W-1:2] - (ADDR_W-2)'(CH_BASE / CH_STRIDE);
      ch_reg = ch_reg_e'(address[1:0]);

      if (address < ADDR_W'(CH_BASE)) begin
         case (address[1:0])
            2'(REG_CTRL): begin
               rd_d[CTRL_EN_BIT]     = en_q;
               rd_d[CTRL_IRQ_EN_BIT] = irq_en_q;
            end
            2'(REG_STATUS): begin
               rd_d[STATUS_AVG_DONE_BIT]       = avg_done_q;
               rd_d[STATUS_OVR_LSB +: NUM_CH] = ovr_q;
            end
            2'(REG_THRESH): rd_d[DATA_W-1:0] = thresh_q;
            2'(REG_RSVD):   rd_d = '0;
            default:        rd_d = '0;
         endcase
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (ch_idx == (ADDR_W-2)'(k)) begin
               case (ch_reg)
                  CH_LIVE: rd_d[DATA_W-1:0] = live_w[k];
                  CH_AVG:  rd_d[DATA_W-1:0] = avg_w[k];
                  CH_MIN:  rd_d[DATA_W-1:0] = min_w[k];
                  CH_MAX:  rd_d[DATA_W-1:0] = max_w[k];
                  default: rd_d = '0;
               endcase
            end
         end
      end
   end

   // Global registers, read data and interrupt with synchronous reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         en_q       <= 1'b0;
         irq_en_q   <= 1'b0;
         avg_done_q <= 1'b0;
         ovr_q      <= '0;
         thresh_q   <= '1;
         cnt_q      <= '0;
         rd_q       <= '0;
         irq_q      <= 1'b0;
      end else begin
         en_q       <= en_d;
         irq_en_q   <= irq_en_d;
         avg_done_q <= avg_done_d;
         ovr_q      <= ovr_d;
         thresh_q   <= thresh_d;
         cnt_q      <= cnt_d;
         rd_q       <= rd_d;
         irq_q      <= irq_d;
      end
   end

   assign readdata = rd_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_qsys_system_ain_bank.sv
// Self-checking bench for qsys_system_ain_bank: constant vector tables,
// directed corner-case sequences and a randomized phase, all compared
// every cycle against a behavioural model of the register map.
module tb_qsys_system_ain_bank;

   localparam int NUM_CH   = 4;
   localparam int DATA_W   = 12;
   localparam int AVG_LOG2 = 2;
   localparam int ADDR_W   = 6;
   localparam int BLK      = 1 << AVG_LOG2;
   localparam int PW       = NUM_CH * DATA_W;

   logic              clk;
   logic              reset_n;
   logic [PW-1:0]     in_port;
   logic              in_valid;
   logic [ADDR_W-1:0] address;
   logic              write;
   logic [31:0]       writedata;
   logic [31:0]       readdata;
   logic              irq;

   qsys_system_ain_bank #(
      .NUM_CH   (NUM_CH),
      .DATA_W   (DATA_W),
      .AVG_LOG2 (AVG_LOG2),
      .ADDR_W   (ADDR_W)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_port   (in_port),
      .in_valid  (in_valid),
      .address   (address),
      .write     (write),
      .writedata (writedata),
      .readdata  (readdata),
      .irq       (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic              m_en, m_irq_en, m_done, m_irq;
   logic [NUM_CH-1:0] m_ovr;
   logic [DATA_W-1:0] m_thresh;
   logic [DATA_W-1:0] m_live [NUM_CH];
   logic [DATA_W-1:0] m_avg  [NUM_CH];
   logic [DATA_W-1:0] m_min  [NUM_CH];
   logic [DATA_W-1:0] m_max  [NUM_CH];
   logic [PW-1:0]     blk_q [$];   // samples of the block in progress

   function automatic logic [DATA_W-1:0] lane(input logic [PW-1:0] v, input int k);
      return v[k*DATA_W +: DATA_W];
   endfunction

   task automatic m_reset();
      m_en = 0; m_irq_en = 0; m_done = 0; m_irq = 0; m_ovr = '0; m_thresh = '1;
      for (int k = 0; k < NUM_CH; k++) begin
         m_live[k] = '0; m_avg[k] = '0; m_min[k] = '1; m_max[k] = '0;
      end
      blk_q.delete();
   endtask

   function automatic logic [31:0] m_read(input logic [ADDR_W-1:0] a);
      int ai, ch, r;
      logic [31:0] v;
      ai = int'(a);
      v  = 32'd0;
      if (ai == 0) begin
         v[0] = m_en; v[1] = m_irq_en;
      end else if (ai == 1) begin
         v[0] = m_done; v[8 +: NUM_CH] = m_ovr;
      end else if (ai == 2) begin
         v = 32'(m_thresh);
      end else if (ai >= 4) begin
         ch = (ai - 4) / 4;
         r  = (ai - 4) % 4;
         if (ch < NUM_CH) begin
            case (r)
               0: v = 32'(m_live[ch]);
               1: v = 32'(m_avg[ch]);
               2: v = 32'(m_min[ch]);
               default: v = 32'(m_max[ch]);
            endcase
         end
      end
      return v;
   endfunction

   // Advance the model by one clock edge using the current input values
   task automatic m_step();
      logic take, mm_clr, done_set;
      logic [NUM_CH-1:0] ovr_set;
      logic [31:0] w1c;
      logic [DATA_W-1:0] s;
      int sum;
      if (!reset_n) begin
         m_reset();
         return;
      end
      take     = in_valid && m_en;
      mm_clr   = write && (address == ADDR_W'(0)) && writedata[2];
      ovr_set  = '0;
      done_set = 0;
      for (int k = 0; k < NUM_CH; k++) begin
         s = lane(in_port, k);
         if (take) begin
            m_live[k] = s;
            if (s > m_thresh) ovr_set[k] = 1'b1;
         end
         if (mm_clr) begin
            m_min[k] = take ? s : '1;
            m_max[k] = take ? s : '0;
         end else if (take) begin
            if (s < m_min[k]) m_min[k] = s;
            if (s > m_max[k]) m_max[k] = s;
         end
      end
      if (take) begin
         blk_q.push_back(in_port);
         if (blk_q.size() == BLK) begin
            for (int k = 0; k < NUM_CH; k++) begin
               sum = 0;
               foreach (blk_q[i]) sum += int'(lane(blk_q[i], k));
               m_avg[k] = DATA_W'(sum / BLK);
            end
            blk_q.delete();
            done_set = 1;
         end
      end
      w1c = 32'd0;
      if (write) begin
         if (address == ADDR_W'(0)) begin
            m_en = writedata[0]; m_irq_en = writedata[1];
         end else if (address == ADDR_W'(1)) begin
            w1c = writedata;
         end else if (address == ADDR_W'(2)) begin
            m_thresh = writedata[DATA_W-1:0];
         end
      end
      m_done = (m_done && !w1c[0]) || done_set;
      m_ovr  = (m_ovr & ~w1c[8 +: NUM_CH]) | ovr_set;
      m_irq  = m_irq_en && (m_done || (|m_ovr));
   endtask

   // ---------------- drivers ----------------
   // One clock: predict, advance model, clock the DUT, compare readdata and irq
   task automatic step();
      logic [31:0] exp_rd;
      logic [ADDR_W-1:0] a;
      a      = address;
      exp_rd = reset_n ? m_read(address) : 32'd0;
      m_step();
      @(posedge clk);
      #1;
      check($sformatf("readdata@%0d", a), readdata, exp_rd);
      check("irq", 32'(irq), 32'(m_irq));
   endtask

   task automatic idle();
      in_valid = 1'b0;
      write    = 1'b0;
   endtask

   task automatic do_read(input int a, output logic [31:0] d);
      idle();
      address = ADDR_W'(a);
      step();
      d = readdata;
   endtask

   task automatic read_check(input string name, input int a, input logic [31:0] exp);
      logic [31:0] d;
      do_read(a, d);
      check(name, d, exp);
   endtask

   task automatic do_write(input int a, input logic [31:0] d);
      in_valid  = 1'b0;
      address   = ADDR_W'(a);
      writedata = d;
      write     = 1'b1;
      step();
      write     = 1'b0;
   endtask

   task automatic do_sample(input int ch, input logic [DATA_W-1:0] s);
      write    = 1'b0;
      in_port  = '0;
      in_port[ch*DATA_W +: DATA_W] = s;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic do_reset(input int n);
      idle();
      reset_n = 1'b0;
      repeat (n) step();
      reset_n = 1'b1;
   endtask

   // ---------------- vector tables ----------------
   typedef struct {
      int          addr;
      logic [31:0] exp;
   } rd_vec_t;

   typedef struct {
      logic [DATA_W-1:0] s;
      logic [31:0]       exp_avg;
      logic [31:0]       exp_status;
   } avg_vec_t;

   rd_vec_t  rd_tbl[$];
   avg_vec_t avg_tbl[$];

   initial begin
      logic [31:0] wd;

      reset_n   = 1'b0;
      in_port   = '0;
      in_valid  = 1'b0;
      address   = '0;
      write     = 1'b0;
      writedata = '0;
      m_reset();

      // Reset-state expectations
      rd_tbl.push_back('{0, 32'h0});
      rd_tbl.push_back('{1, 32'h0});
      rd_tbl.push_back('{2, 32'hFFF});
      rd_tbl.push_back('{3, 32'h0});
      for (int k = 0; k < NUM_CH; k++) begin
         rd_tbl.push_back('{4 + 4*k + 0, 32'h0});
         rd_tbl.push_back('{4 + 4*k + 1, 32'h0});
         rd_tbl.push_back('{4 + 4*k + 2, 32'hFFF});
         rd_tbl.push_back('{4 + 4*k + 3, 32'h0});
      end
      rd_tbl.push_back('{20, 32'h0});
      rd_tbl.push_back('{45, 32'h0});
      rd_tbl.push_back('{63, 32'h0});

      // Ch0 averaging block: 10,20,30,41 -> (101 >> 2) = 25 on the fourth sample
      avg_tbl.push_back('{12'd10, 32'd0,  32'd0});
      avg_tbl.push_back('{12'd20, 32'd0,  32'd0});
      avg_tbl.push_back('{12'd30, 32'd0,  32'd0});
      avg_tbl.push_back('{12'd41, 32'd25, 32'd1});

      // ---- reset state ----
      do_reset(3);
      check("rst_readdata", readdata, 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      foreach (rd_tbl[i]) read_check($sformatf("reset_rd@%0d", rd_tbl[i].addr), rd_tbl[i].addr, rd_tbl[i].exp);

      // ---- averaging ----
      do_write(0, 32'h1);
      read_check("ctrl_en", 0, 32'h1);
      foreach (avg_tbl[i]) begin
         do_sample(0, avg_tbl[i].s);
         read_check($sformatf("avg0[%0d]", i), 5, avg_tbl[i].exp_avg);
         read_check($sformatf("status_avg[%0d]", i), 1, avg_tbl[i].exp_status);
      end
      read_check("live0", 4, 32'd41);

      // ---- threshold and irq ----
      do_write(1, 32'h1);
      do_write(2, 32'h800);
      do_write(0, 32'h3);
      do_sample(2, 12'h800);
      check("irq_at_thresh", 32'(irq), 32'd0);
      read_check("no_ovr_at_thresh", 1, 32'h0);
      do_sample(2, 12'h801);
      check("irq_ovr", 32'(irq), 32'd1);
      read_check("status_ovr2", 1, 32'h400);
      do_write(1, 32'h400);
      check("irq_cleared", 32'(irq), 32'd0);
      read_check("status_cleared", 1, 32'h0);

      // ---- min/max and MM_CLR ----
      do_write(0, 32'h7);
      read_check("ctrl_mmclr_reads0", 0, 32'h3);
      do_sample(1, 12'd5);
      do_sample(1, 12'h900);
      do_sample(1, 12'd3);
      read_check("min1", 10, 32'd3);
      read_check("max1", 11, 32'h900);
      in_port   = '0;
      in_port[1*DATA_W +: DATA_W] = 12'd7;
      in_valid  = 1'b1;
      address   = ADDR_W'(0);
      writedata = 32'h7;
      write     = 1'b1;
      step();
      idle();
      read_check("min1_clr_sample", 10, 32'd7);
      read_check("max1_clr_sample", 11, 32'd7);
      read_check("min0_clr_sample", 6, 32'd0);

      // ---- EN=0 holds the block, resume mid-block ----
      do_reset(2);
      do_write(0, 32'h1);
      do_sample(3, 12'd100);
      do_sample(3, 12'd200);
      do_write(0, 32'h0);
      do_sample(3, 12'd999);
      do_sample(3, 12'd999);
      read_check("live3_held", 16, 32'd200);
      read_check("avg3_held", 17, 32'd0);
      read_check("status_held", 1, 32'd0);
      do_write(0, 32'h1);
      do_sample(3, 12'd300);
      read_check("status_resume3", 1, 32'd0);
      do_sample(3, 12'd404);
      read_check("avg3_resume", 17, 32'd251);
      read_check("status_resume4", 1, 32'd1);

      // ---- W1C coinciding with a completing sample: set wins ----
      do_write(1, 32'h1);
      read_check("status_w1c", 1, 32'd0);
      do_sample(3, 12'd1);
      do_sample(3, 12'd2);
      do_sample(3, 12'd3);
      in_port   = '0;
      in_port[3*DATA_W +: DATA_W] = 12'd8;
      in_valid  = 1'b1;
      address   = ADDR_W'(1);
      writedata = 32'h1;
      write     = 1'b1;
      step();
      idle();
      read_check("status_set_wins", 1, 32'd1);
      read_check("avg3_w1c_block", 17, 32'd3);

      // ---- reset mid-block discards the partial sum ----
      do_write(1, 32'h1);
      do_sample(3, 12'd1000);
      do_sample(3, 12'd1000);
      do_reset(1);
      do_write(0, 32'h1);
      do_sample(3, 12'd4);
      do_sample(3, 12'd8);
      read_check("avg3_after_rst_partial", 17, 32'd0);
      read_check("status_after_rst_partial", 1, 32'd0);
      do_sample(3, 12'd12);
      do_sample(3, 12'd16);
      read_check("avg3_fresh_block", 17, 32'd10);
      read_check("status_fresh_block", 1, 32'd1);

      // ---- randomized phase against the model ----
      for (int c = 0; c < 2000; c++) begin
         reset_n  = ($urandom_range(0, 299) != 0);
         in_valid = ($urandom_range(0, 2) != 0);
         for (int k = 0; k < NUM_CH; k++) in_port[k*DATA_W +: DATA_W] = DATA_W'($urandom);
         write = ($urandom_range(0, 5) == 0);
         wd    = $urandom;
         if (write) begin
            address = ADDR_W'($urandom_range(0, 2));
            if (address == ADDR_W'(0)) begin
               wd[0] = ($urandom_range(0, 3) != 0);
               wd[2] = ($urandom_range(0, 5) == 0);
            end
         end else begin
            address = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
         end
         writedata = wd;
         step();
      end
      reset_n = 1'b1;
      idle();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
